fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch stage directly downstream of the PC register. Each cycle
//  it may issue Current_PC to instruction memory and raise pc_advance so that
//  next-PC logic steps the PC. It holds fetched words, tagged with their PC, in
//  a DEPTH-entry in-order queue. It presents them to decode over a valid/ready
//  handshake and drops stale responses after a branch/jump flush.
// PARAMETERS
//  DATA_WIDTH  32  width of PC, address and instruction
//  DEPTH       4   queue entries; power of 2, >= 2
// PORTS
//  clk          in   1           clock; all state updates on posedge
//  rst          in   1           asynchronous, active-low reset
//  Current_PC   in   DATA_WIDTH  PC register output, address to fetch
//  pc_advance   out  1           issue this cycle; next-PC logic steps PC
//  flush        in   1           redirect; discard queue and in-flight fetches
//  imem_req     out  1           fetch request, always accepted by memory
//  imem_addr    out  DATA_WIDTH  {Current_PC[31:2],2'b00}
//  imem_rvalid  in   1           response valid; in order, latency >= 1 cycle
//  imem_rdata   in   DATA_WIDTH  response instruction word
//  instr_valid  out  1           queue head holds a fetched instruction
//  instr_ready  in   1           decode accepts the head this cycle
//  instr_out    out  DATA_WIDTH  head instruction
//  instr_pc     out  DATA_WIDTH  PC of head instruction
// BEHAVIOUR
//  - Reset (rst=0, async): head/tail/fill pointers=0, all entries empty, discard_cnt=0.
//    Outputs: imem_req=0, pc_advance=0, instr_valid=0, instr_out=0, instr_pc=0.
//  - Entry state: {pc, instr, filled}.
//    alloc_cnt = allocated entries; unfilled = allocated && !filled.
//  - Issue: issue = !flush && alloc_cnt < DEPTH, combinational.
//    imem_req = pc_advance = issue.
//    On issue the tail entry is allocated with pc=Current_PC, filled=0; tail++.
//  - Full: issue is blocked when alloc_cnt==DEPTH, even if a pop occurs the same
//    cycle (no bypass). It resumes the cycle after alloc_cnt drops.
//  - Response: if imem_rvalid && discard_cnt>0, decrement discard_cnt and drop the
//    data. Otherwise write imem_rdata to the fill pointer entry, set filled, fill++.
//    An imem_rvalid with no outstanding request is a protocol error (assertion).
//  - Output: instr_valid = head allocated && filled; instr_out/instr_pc read from head.
//    The first instruction is visible the cycle after its response (registered).
//  - Pop: instr_valid && instr_ready frees the head; head++.
//    While instr_valid && !instr_ready, instr_out and instr_pc are held stable.
//  - Flush: no issue that cycle, pc_advance=0. All entries are emptied and
//    head=tail=fill=0. discard_cnt <= discard_cnt + unfilled - imem_rvalid;
//    a response arriving in the flush cycle is dropped. instr_valid=0 next cycle.
//    The PC is assumed redirected in the same cycle; fetch of the target starts next cycle.
//  - Flush overrides pop and response-fill in the same cycle.
//    Flush together with reset: reset wins.
//  - Pointers are log2(DEPTH) bits and wrap; alloc_cnt and discard_cnt are
//    log2(DEPTH)+1 bits. discard_cnt + alloc_cnt <= DEPTH always
//    (assertion); issue also requires alloc_cnt + discard_cnt < DEPTH.
//  - Reset mid-operation: all state cleared immediately; late responses after
//    reset release are the environment's responsibility (memory is also reset).
// TESTING
//  1 Stream: PC 0,4,8..., latency 1, ready=1 -> instr_valid from cycle 3;
//    instr_pc 0,4,8 in order; pc_advance=1 every cycle.
//  2 Backpressure: ready=0 with DEPTH=4 -> exactly 4 requests, then
//    pc_advance=0. Head stable at pc=0. Raise ready -> issue resumes the next
//    cycle; no loss or duplication.
//  3 Flush with 2 in flight (latency 3) -> next 2 rvalids dropped.
//    Fetch of target 0x100 is issued the cycle after flush;
//    first instr_pc = 0x100.
//  4 Flush coincident with rvalid and 1 other unfilled -> discard_cnt=1;
//    one later response dropped.
//  5 Misaligned Current_PC=0x0000_0006 -> imem_addr=0x0000_0004,
//    instr_pc=0x0000_0006.
//  6 Async rst low mid-stream between edges -> instr_valid, imem_req drop
//    immediately; queue empty after release.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage that sits right after the PC register.
// It issues the current PC to instruction memory, keeps the fetched words in a
// small in-order queue tagged with their PC, hands them to decode over a
// valid/ready handshake, and counts off stale responses after a redirect.
module fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Current_PC,
  output logic                  pc_advance,
  input  logic                  flush,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [DATA_WIDTH-1:0] instr_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry storage: PC tag, fetched word and a filled flag per slot
  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [DEPTH-1:0]      filled;

  // head = oldest entry, tail = next slot to allocate, fill = next slot to receive data
  logic [PW-1:0] head, tail, fill;

  // alloc_cnt = allocated entries, pend_cnt = allocated but not yet filled,
  // discard_cnt = responses still owed by memory for requests killed by a flush
  logic [CW-1:0] alloc_cnt, pend_cnt, discard_cnt;

  logic          issue, pop, drop, write;
  logic [CW-1:0] occupancy;

  // Issue/accept decisions; stale responses are consumed before any fill
  always_comb begin
    occupancy   = alloc_cnt + discard_cnt;
    issue       = rst && !flush && (alloc_cnt < DEPTH_C) && (occupancy < DEPTH_C);
    drop        = imem_rvalid && (discard_cnt != '0);
    write       = rst && !flush && imem_rvalid && (discard_cnt == '0) && (pend_cnt != '0);
    instr_valid = (alloc_cnt != '0) && filled[head];
    pop         = instr_valid && instr_ready && !flush;
    pc_advance  = issue;
    imem_req    = issue;
    imem_addr   = Current_PC & ~DATA_WIDTH'(3);
    instr_out   = instr_valid ? instr_mem[head] : '0;
    instr_pc    = instr_valid ? pc_mem[head]    : '0;
  end

  // Pointers, counters and filled flags; a flush empties the queue and turns
  // every unfilled request into a response that must be thrown away
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head        <= '0;
      tail        <= '0;
      fill        <= '0;
      alloc_cnt   <= '0;
      pend_cnt    <= '0;
      discard_cnt <= '0;
      filled      <= '0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      fill        <= '0;
      alloc_cnt   <= '0;
      pend_cnt    <= '0;
      filled      <= '0;
      discard_cnt <= discard_cnt + pend_cnt - CW'(imem_rvalid);
    end else begin
      if (issue) begin
        tail         <= tail + PW'(1);
        filled[tail] <= 1'b0;
      end
      if (write) begin
        fill         <= fill + PW'(1);
        filled[fill] <= 1'b1;
      end
      if (pop) begin
        head         <= head + PW'(1);
        filled[head] <= 1'b0;
      end
      if (drop) begin
        discard_cnt <= discard_cnt - CW'(1);
      end
      alloc_cnt <= alloc_cnt + CW'(issue) - CW'(pop);
      pend_cnt  <= pend_cnt  + CW'(issue) - CW'(write);
    end
  end

  // Payload storage needs no reset: nothing is visible until its filled flag is set
  always_ff @(posedge clk) begin
    if (issue) begin
      pc_mem[tail] <= Current_PC;
    end
    if (write) begin
      instr_mem[fill] <= imem_rdata;
    end
  end

  // Memory must never answer a request that was not made
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> ((discard_cnt != '0) || (pend_cnt != '0)));

  // Owed responses plus live entries can never exceed the queue size
  a_capacity: assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, discard_cnt} + {1'b0, alloc_cnt}) <= {1'b0, DEPTH_C});

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a
// queue-based reference model of fetched entries and memory responses.
module tb_fetch_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] Current_PC = '0;
  logic          pc_advance;
  logic          flush = 1'b0;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic          imem_rvalid = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr_out;
  logic [DW-1:0] instr_pc;

  fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .Current_PC(Current_PC), .pc_advance(pc_advance),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  // Reference model: entries decode should see, and responses memory still owes
  typedef struct {logic [DW-1:0] pc; logic [DW-1:0] data; bit filled;} entry_t;
  typedef struct {int due; logic [DW-1:0] data; int epoch;} resp_t;

  entry_t model_q[$];
  resp_t  mem_q[$];
  int     cyc = 0, epoch = 0, lat = 1, last_due = 0;
  bit     rand_lat = 0;
  int     n_cmp = 0, n_fail = 0;
  logic [DW-1:0] pc_next = '0;

  logic          obs_adv, obs_req, obs_valid;
  logic [DW-1:0] obs_addr, obs_out, obs_pc;
  bit            exp_issue, exp_valid;
  logic [DW-1:0] exp_pc, exp_out, exp_addr;

  // One clock cycle: drive inputs at negedge, compute expectations from the
  // model, sample the DUT, then advance memory and model at the posedge
  task automatic step(input bit f, input bit r, input logic [DW-1:0] tgt);
    int    stale;
    bit    dlv;
    bit    done;
    resp_t dr;
    resp_t nr;
    entry_t e;
    @(negedge clk);
    Current_PC  = pc_next;
    flush       = f;
    instr_ready = r;
    dlv         = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      dr = mem_q.pop_front();
      dlv = 1;
      imem_rvalid = 1'b1;
      imem_rdata = dr.data;
    end
    stale = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
    if (dlv && dr.epoch != epoch) stale++;
    exp_issue = !f && (model_q.size() + stale < DEPTH);
    exp_valid = (model_q.size() > 0) && model_q[0].filled;
    exp_pc    = exp_valid ? model_q[0].pc : '0;
    exp_out   = exp_valid ? model_q[0].data : '0;
    exp_addr  = (Current_PC >> 2) << 2;
    #1;
    obs_adv = pc_advance; obs_req = imem_req; obs_valid = instr_valid;
    obs_addr = imem_addr; obs_out = instr_out; obs_pc = instr_pc;
    @(posedge clk);
    if (obs_req === 1'b1) begin
      nr.due = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
      if (nr.due <= last_due) nr.due = last_due + 1;
      last_due = nr.due;
      nr.data = $urandom;
      nr.epoch = epoch;
      mem_q.push_back(nr);
    end
    if (f) begin
      model_q.delete();
      epoch++;
    end else begin
      if (dlv && dr.epoch == epoch) begin
        done = 0;
        for (int i = 0; i < model_q.size(); i++) begin
          if (!done && !model_q[i].filled) begin
            model_q[i].filled = 1;
            model_q[i].data = dr.data;
            done = 1;
          end
        end
      end
      if (exp_valid && r) model_q.delete(0);
      if (exp_issue) begin
        e.pc = Current_PC; e.data = '0; e.filled = 0;
        model_q.push_back(e);
      end
    end
    pc_next = f ? tgt : (obs_adv === 1'b1 ? Current_PC + 32'd4 : Current_PC);
    cyc++;
  endtask

  // Hold reset for a cycle and release it between edges with the PC at start
  task automatic apply_reset(input logic [DW-1:0] start);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    model_q.delete(); mem_q.delete();
    last_due = 0; pc_next = start; Current_PC = start;
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; instr_ready = 1'b1;
    #1;
    n_cmp++;
    if ({imem_req, pc_advance, instr_valid} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_ctrl req/adv/valid got %b%b%b want 000", imem_req, pc_advance, instr_valid);
    end
    n_cmp++;
    if (instr_out !== '0 || instr_pc !== '0) begin
      n_fail++; $display("[TB] FAIL reset_data out/pc got %h/%h want 0/0", instr_out, instr_pc);
    end
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic test_stream();
    int first = -1;
    int npop = 0;
    rand_lat = 0; lat = 1;
    apply_reset('0);
    for (int c = 1; c <= 20; c++) begin
      step(0, 1, '0);
      n_cmp++;
      if ({obs_adv, obs_req, obs_valid} !== {exp_issue, exp_issue, exp_valid} || obs_adv !== 1'b1) begin
        n_fail++; $display("[TB] FAIL stream_ctrl c=%0d adv/req/valid got %b%b%b want %b%b%b", c, obs_adv, obs_req, obs_valid, exp_issue, exp_issue, exp_valid);
      end
      if (obs_valid === 1'b1) begin
        if (first < 0) first = c;
        n_cmp++;
        if (obs_pc !== DW'(4 * npop) || obs_out !== exp_out) begin
          n_fail++; $display("[TB] FAIL stream_head c=%0d pc/instr got %h/%h want %h/%h", c, obs_pc, obs_out, DW'(4 * npop), exp_out);
        end
        npop++;
      end
    end
    n_cmp++;
    if (first != 3) begin
      n_fail++; $display("[TB] FAIL stream_first_valid got cycle %0d want 3", first);
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    int npop = 0;
    rand_lat = 0; lat = 1;
    apply_reset('0);
    for (int c = 1; c <= 10; c++) begin
      step(0, 0, '0);
      if (obs_req === 1'b1) nreq++;
      n_cmp++;
      if ({obs_adv, obs_valid} !== {exp_issue, exp_valid} || (obs_valid === 1'b1 && obs_pc !== '0)) begin
        n_fail++; $display("[TB] FAIL bp_hold c=%0d adv/valid/pc got %b%b/%h want %b%b/0", c, obs_adv, obs_valid, obs_pc, exp_issue, exp_valid);
      end
    end
    n_cmp++;
    if (nreq != DEPTH) begin
      n_fail++; $display("[TB] FAIL bp_req_count got %0d want %0d", nreq, DEPTH);
    end
    for (int c = 0; c < 16; c++) begin
      step(0, 1, '0);
      if (c < 2) begin
        n_cmp++;
        if (obs_adv !== (c == 1)) begin
          n_fail++; $display("[TB] FAIL bp_resume c=%0d adv got %b want %b", c, obs_adv, c == 1);
        end
      end
      n_cmp++;
      if ({obs_adv, obs_valid} !== {exp_issue, exp_valid}) begin
        n_fail++; $display("[TB] FAIL bp_ctrl c=%0d adv/valid got %b%b want %b%b", c, obs_adv, obs_valid, exp_issue, exp_valid);
      end
      if (obs_valid === 1'b1) begin
        n_cmp++;
        if (obs_pc !== DW'(4 * npop) || obs_out !== exp_out) begin
          n_fail++; $display("[TB] FAIL bp_order pc/instr got %h/%h want %h/%h", obs_pc, obs_out, DW'(4 * npop), exp_out);
        end
        npop++;
      end
    end
  endtask

  // Redirect after a couple of fetches; the first instruction seen must be the target
  task automatic test_flush(input int l, input logic [DW-1:0] tgt, input string tag);
    bit seen = 0;
    rand_lat = 0; lat = l;
    apply_reset('0);
    step(0, 1, '0);
    step(0, 1, '0);
    step(1, 1, tgt);
    n_cmp++;
    if (obs_adv !== 1'b0 || obs_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL %s_flush_cycle adv/valid got %b%b want 00", tag, obs_adv, obs_valid);
    end
    step(0, 1, '0);
    n_cmp++;
    if (obs_adv !== 1'b1 || obs_addr !== tgt) begin
      n_fail++; $display("[TB] FAIL %s_target_issue adv/addr got %b/%h want 1/%h", tag, obs_adv, obs_addr, tgt);
    end
    for (int c = 0; c < 15 && !seen; c++) begin
      step(0, 1, '0);
      n_cmp++;
      if ({obs_adv, obs_valid} !== {exp_issue, exp_valid} || (exp_valid && obs_out !== exp_out)) begin
        n_fail++; $display("[TB] FAIL %s_ctrl c=%0d adv/valid/instr got %b%b/%h want %b%b/%h", tag, c, obs_adv, obs_valid, obs_out, exp_issue, exp_valid, exp_out);
      end
      if (obs_valid === 1'b1) begin
        seen = 1;
        n_cmp++;
        if (obs_pc !== tgt) begin
          n_fail++; $display("[TB] FAIL %s_first_pc got %h want %h", tag, obs_pc, tgt);
        end
      end
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL %s_timeout instr_valid never rose", tag);
    end
  endtask

  task automatic test_misaligned();
    bit seen = 0;
    rand_lat = 0; lat = 1;
    apply_reset(32'h0000_0006);
    step(0, 1, '0);
    n_cmp++;
    if (obs_adv !== 1'b1 || obs_addr !== 32'h0000_0004) begin
      n_fail++; $display("[TB] FAIL misaligned_addr adv/addr got %b/%h want 1/00000004", obs_adv, obs_addr);
    end
    for (int c = 0; c < 6 && !seen; c++) begin
      step(0, 1, '0);
      if (obs_valid === 1'b1) begin
        seen = 1;
        n_cmp++;
        if (obs_pc !== 32'h0000_0006 || obs_out !== exp_out) begin
          n_fail++; $display("[TB] FAIL misaligned_pc pc/instr got %h/%h want 00000006/%h", obs_pc, obs_out, exp_out);
        end
      end
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL misaligned_timeout instr_valid never rose");
    end
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    rand_lat = 0; lat = 2;
    apply_reset('0);
    for (int c = 0; c < 6; c++) step(0, c % 2 == 1, '0);
    #7 rst = 1'b0;
    #1;
    n_cmp++;
    if ({instr_valid, imem_req, pc_advance} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL async_reset_drop valid/req/adv got %b%b%b want 000", instr_valid, imem_req, pc_advance);
    end
    model_q.delete(); mem_q.delete();
    flush = 1'b0; imem_rvalid = 1'b0; last_due = 0;
    pc_next = 32'h40; Current_PC = 32'h40;
    @(posedge clk);
    #2 rst = 1'b1;
    step(0, 1, '0);
    n_cmp++;
    if (obs_valid !== 1'b0 || obs_adv !== 1'b1 || obs_addr !== 32'h40) begin
      n_fail++; $display("[TB] FAIL async_reset_empty valid/adv/addr got %b%b/%h want 01/00000040", obs_valid, obs_adv, obs_addr);
    end
    for (int c = 0; c < 8 && !seen; c++) begin
      step(0, 1, '0);
      if (obs_valid === 1'b1) begin
        seen = 1;
        n_cmp++;
        if (obs_pc !== 32'h40 || obs_out !== exp_out) begin
          n_fail++; $display("[TB] FAIL async_reset_first pc/instr got %h/%h want 00000040/%h", obs_pc, obs_out, exp_out);
        end
      end
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL async_reset_timeout instr_valid never rose");
    end
  endtask

  task automatic test_random();
    bit f, r;
    logic [DW-1:0] tgt;
    rand_lat = 1;
    apply_reset(32'h1000);
    for (int c = 0; c < 400; c++) begin
      f = ($urandom_range(0, 99) < 6);
      r = ($urandom_range(0, 99) < 65);
      tgt = $urandom;
      step(f, r, tgt);
      n_cmp++;
      if ({obs_adv, obs_req, obs_valid} !== {exp_issue, exp_issue, exp_valid}) begin
        n_fail++; $display("[TB] FAIL random_ctrl c=%0d adv/req/valid got %b%b%b want %b%b%b", c, obs_adv, obs_req, obs_valid, exp_issue, exp_issue, exp_valid);
      end
      if (exp_issue) begin
        n_cmp++;
        if (obs_addr !== exp_addr) begin
          n_fail++; $display("[TB] FAIL random_addr c=%0d got %h want %h", c, obs_addr, exp_addr);
        end
      end
      if (exp_valid) begin
        n_cmp++;
        if (obs_pc !== exp_pc || obs_out !== exp_out) begin
          n_fail++; $display("[TB] FAIL random_head c=%0d pc/instr got %h/%h want %h/%h", c, obs_pc, obs_out, exp_pc, exp_out);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush(3, 32'h0000_0100, "flush_inflight");
    test_flush(2, 32'h0000_0200, "flush_rvalid");
    test_misaligned();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
